// File: rtl/eco_stage_pkg.sv
// Shared widths, FSM states and core pin mapping for the ECO vector issue/capture stage.
package eco_stage_pkg;

    localparam int VEC_IN_W  = 11;
    localparam int VEC_OUT_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Core input gi sits on in_vec/core_in bit i.
    localparam int G0_IDX  = 0;
    localparam int G1_IDX  = 1;
    localparam int G2_IDX  = 2;
    localparam int G3_IDX  = 3;
    localparam int G4_IDX  = 4;
    localparam int G5_IDX  = 5;
    localparam int G6_IDX  = 6;
    localparam int G7_IDX  = 7;
    localparam int G8_IDX  = 8;
    localparam int G9_IDX  = 9;
    localparam int G10_IDX = 10;

    // Core outputs g11..g16 sit on core_out/out_vec bits 0..5.
    localparam int G11_IDX = 0;
    localparam int G12_IDX = 1;
    localparam int G13_IDX = 2;
    localparam int G14_IDX = 3;
    localparam int G15_IDX = 4;
    localparam int G16_IDX = 5;

endpackage

// File: rtl/eco_vec_fifo.sv
// DEPTH x 11 synchronous vector FIFO with registered count; a pushed entry is
// visible at rdata only from the cycle after the push.
module eco_vec_fifo
    import eco_stage_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [VEC_IN_W-1:0]     wdata,
    output logic [VEC_IN_W-1:0]     rdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [VEC_IN_W-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;

    // NOTE: the storage array is deliberately not reset; pointers and count
    // alone decide which entries are live, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/eco_vec_stage.sv
// Issue/capture stage around the combinational ECO core: queues vectors, drives
// core_in, waits SETTLE cycles, registers core_out and hands it downstream.
module eco_vec_stage
    import eco_stage_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [VEC_IN_W-1:0]   in_vec,
    output logic [VEC_IN_W-1:0]   core_in,
    input  logic [VEC_OUT_W-1:0]  core_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [VEC_OUT_W-1:0]  out_vec,
    output logic [CNT_W-1:0]      issued_cnt,
    output logic                  busy
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [3:0]              settle_cnt;
    logic                    issue;
    logic                    capture;
    logic                    release_out;
    logic                    fifo_push;
    logic [VEC_IN_W-1:0]     fifo_rdata;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    fifo_full;
    logic                    fifo_empty;

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;

    eco_vec_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (issue),
        .wdata (in_vec),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        issue       = 1'b0;
        capture     = 1'b0;
        release_out = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    issue     = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (settle_cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                // Accepted result with more work queued reissues on the same edge.
                if (out_ready) begin
                    release_out = 1'b1;
                    if (!fifo_empty) begin
                        issue     = 1'b1;
                        state_nxt = DRIVE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_in    <= '0;
            settle_cnt <= '0;
            out_valid  <= 1'b0;
            out_vec    <= '0;
            issued_cnt <= '0;
        end else begin
            if (issue) begin
                core_in    <= fifo_rdata;
                settle_cnt <= SETTLE_LOAD;
                if (issued_cnt != '1) issued_cnt <= issued_cnt + 1'b1;
            end else if (state == DRIVE && settle_cnt != 4'd0) begin
                settle_cnt <= settle_cnt - 1'b1;
            end

            if (capture) begin
                out_vec   <= core_out;
                out_valid <= 1'b1;
            end else if (release_out) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE) || (fifo_count != '0);

endmodule
